// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle spawn scheduler: owns a pool of obstacle sprite slots. It issues one
// spawn per spawn period into the next free slot (round-robin) on an LFSR lane,
// frees slots as obstacles leave the screen, flushes the pool on a collision,
// and shortens the spawn period as play goes on.
module obstacle_spawn_scheduler #(
  parameter int          NUM_SLOTS      = 10,
  parameter int          TICK_DIV       = 50000000,
  parameter int          PERIOD_INIT    = 2,
  parameter int          PERIOD_MIN     = 1,
  parameter int          SPEEDUP_EVERY  = 8,
  parameter int          COOLDOWN_TICKS = 3,
  parameter int          LANE_W         = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         enable,
  input  logic                         collision,
  input  logic [NUM_SLOTS-1:0]         slot_done,
  output logic [NUM_SLOTS-1:0]         slot_active,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
  output logic [LANE_W-1:0]            spawn_lane,
  output logic [7:0]                   period,
  output logic [15:0]                  spawn_count,
  output logic                         level_up
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CYC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, COOLDOWN} state_t;

  state_t            state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [7:0]        tick_cnt;
  logic              pending;
  logic              coll_prev;
  logic [15:0]       lfsr;
  logic [SLOT_W-1:0] rr_ptr;

  logic                 tick;
  logic                 coll_edge;
  logic [8:0]           tick_next;
  logic                 due;
  logic                 cool_done;
  logic                 found;
  logic [SLOT_W-1:0]    pick;
  logic [SLOT_W:0]      scan;
  logic                 do_spawn;
  logic [NUM_SLOTS-1:0] spawn_mask;
  logic [15:0]          count_inc;
  logic                 speed_up;

  // Tick generation, collision edge and spawn-due detection.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    tick      = (cyc_cnt == CYC_W'(TICK_DIV - 1));
    coll_edge = collision & ~coll_prev;
    tick_next = {1'b0, tick_cnt} + 9'd1;
    // A period shortened while a spawn was pending can leave tick_cnt past it; >= catches that.
    due       = tick && (tick_next >= {1'b0, period});
    cool_done = tick && (tick_next >= 9'(COOLDOWN_TICKS));
  end

  // Round-robin search for the first free slot starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      scan = {1'b0, rr_ptr} + (SLOT_W + 1)'(i);
      if (scan >= (SLOT_W + 1)'(NUM_SLOTS)) scan = scan - (SLOT_W + 1)'(NUM_SLOTS);
      if (!found && !slot_active[scan[SLOT_W-1:0]]) begin
        found = 1'b1;
        pick  = scan[SLOT_W-1:0];
      end
    end
  end

  // Spawn decision, saturating spawn count and speed-up condition.
  always_comb begin
    do_spawn   = (state == RUN) && enable && !coll_edge && (pending || due) && found;
    spawn_mask = '0;
    if (do_spawn) spawn_mask[pick] = 1'b1;
    count_inc  = (spawn_count == 16'hFFFF) ? spawn_count : spawn_count + 16'd1;
    speed_up   = (count_inc % 16'(SPEEDUP_EVERY) == 16'd0) && (count_inc != 16'd0)
                 && (period > 8'(PERIOD_MIN));
  end

  // State machine, slot pool bookkeeping and all registered outputs.
  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    if (Reset) begin
      state       <= IDLE;
      slot_active <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_lane  <= '0;
      level_up    <= 1'b0;
      spawn_count <= '0;
      period      <= 8'(PERIOD_INIT);
      rr_ptr      <= '0;
      pending     <= 1'b0;
      cyc_cnt     <= '0;
      tick_cnt    <= '0;
      lfsr        <= LFSR_SEED;
      coll_prev   <= 1'b0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      coll_prev   <= collision;
      spawn_valid <= 1'b0;
      level_up    <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        slot_active <= '0;
        pending     <= 1'b0;
        cyc_cnt     <= '0;
        tick_cnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state       <= RUN;
            slot_active <= '0;
            pending     <= 1'b0;
            cyc_cnt     <= '0;
            tick_cnt    <= '0;
          end
          RUN: begin
            if (coll_edge) begin
              // The flush takes priority over any spawn due in the same cycle.
              state       <= FLUSH;
              slot_active <= '0;
              pending     <= 1'b0;
              cyc_cnt     <= '0;
              tick_cnt    <= '0;
              period      <= 8'(PERIOD_INIT);
              spawn_count <= '0;
            end else begin
              cyc_cnt <= tick ? '0 : cyc_cnt + CYC_W'(1);
              if (tick) tick_cnt <= due ? 8'd0 : tick_next[7:0];
              slot_active <= (slot_active & ~slot_done) | spawn_mask;
              if (do_spawn) begin
                spawn_valid <= 1'b1;
                spawn_slot  <= pick;
                spawn_lane  <= lfsr[LANE_W-1:0];
                rr_ptr      <= (pick == SLOT_W'(NUM_SLOTS - 1)) ? '0 : pick + SLOT_W'(1);
                pending     <= 1'b0;
                spawn_count <= count_inc;
                if (speed_up) begin
                  period   <= period - 8'd1;
                  level_up <= 1'b1;
                end
              end else if (due) begin
                pending <= 1'b1;
              end
            end
          end
          FLUSH: begin
            state       <= COOLDOWN;
            slot_active <= '0;
            pending     <= 1'b0;
            cyc_cnt     <= '0;
            tick_cnt    <= '0;
            period      <= 8'(PERIOD_INIT);
            spawn_count <= '0;
          end
          COOLDOWN: begin
            cyc_cnt <= tick ? '0 : cyc_cnt + CYC_W'(1);
            if (tick) tick_cnt <= tick_next[7:0];
            if (cool_done) begin
              state    <= RUN;
              tick_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Self-checking bench for obstacle_spawn_scheduler (TICK_DIV=4, defaults otherwise).
module tb_obstacle_spawn_scheduler;

  localparam int NS      = 10;
  localparam int TD      = 4;
  localparam int P_INIT  = 2;
  localparam int P_MIN   = 1;
  localparam int SPEEDUP = 8;
  localparam int COOL    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          Clk;
  logic          Reset;
  logic          enable;
  logic          collision;
  logic [NS-1:0] slot_done;
  logic [NS-1:0] slot_active;
  logic          spawn_valid;
  logic [3:0]    spawn_slot;
  logic [1:0]    spawn_lane;
  logic [7:0]    period;
  logic [15:0]   spawn_count;
  logic          level_up;

  int checks   = 0;
  int failures = 0;

  obstacle_spawn_scheduler #(.NUM_SLOTS(NS), .TICK_DIV(TD)) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .collision(collision),
    .slot_done(slot_done), .slot_active(slot_active), .spawn_valid(spawn_valid),
    .spawn_slot(spawn_slot), .spawn_lane(spawn_lane), .period(period),
    .spawn_count(spawn_count), .level_up(level_up)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_PLAY, M_FLUSH, M_COOL} mode_t;

  mode_t         m_mode;
  logic [NS-1:0] m_active;
  bit            m_valid, m_lvl, m_pending, m_prev;
  int            m_slot, m_rr, m_period, m_count;
  int            m_phase;   // cycles spent in the current timed phase
  int            m_ticks;   // ticks since the last due event / since cooldown start
  logic [1:0]    m_lane;
  logic [15:0]   m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [1:0] seed_lane(input int steps);
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < steps; i++) v = lfsr_next(v);
    return v[1:0];
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_active = '0; m_valid = 0; m_lvl = 0; m_pending = 0; m_prev = 0;
    m_slot = 0; m_rr = 0; m_period = P_INIT; m_count = 0; m_phase = 0; m_ticks = 0;
    m_lane = 2'b00; m_lfsr = SEED;
  endtask

  task automatic model_clear_pool();
    m_active = '0; m_pending = 0; m_phase = 0; m_ticks = 0;
  endtask

  task automatic model_step(input bit en, input bit coll, input logic [NS-1:0] done);
    bit         edge_c, tick, due;
    int         s;
    logic [1:0] lane_now;
    edge_c   = coll && !m_prev;
    m_prev   = coll;
    lane_now = m_lfsr[1:0];
    m_lfsr   = lfsr_next(m_lfsr);
    m_valid  = 0;
    m_lvl    = 0;
    if (!en) begin
      m_mode = M_IDLE;
      model_clear_pool();
    end else if (m_mode == M_IDLE) begin
      m_mode = M_PLAY;
      model_clear_pool();
    end else if (m_mode == M_FLUSH) begin
      m_mode = M_COOL;
      model_clear_pool();
    end else if (m_mode == M_COOL) begin
      tick = (m_phase % TD) == TD - 1;
      m_phase++;
      if (tick) begin
        m_ticks++;
        if (m_ticks >= COOL) begin
          m_mode = M_PLAY; m_phase = 0; m_ticks = 0;
        end
      end
    end else if (edge_c) begin
      m_mode = M_FLUSH;
      model_clear_pool();
      m_period = P_INIT;
      m_count  = 0;
    end else begin
      tick = (m_phase % TD) == TD - 1;
      m_phase++;
      due = 0;
      if (tick) begin
        m_ticks++;
        if (m_ticks >= m_period) begin
          m_ticks = 0; due = 1;
        end
      end
      s = -1;
      if (m_pending || due)
        for (int k = 0; k < NS; k++)
          if (s < 0 && !m_active[(m_rr + k) % NS]) s = (m_rr + k) % NS;
      m_active = m_active & ~done;
      if (s >= 0) begin
        m_active[s] = 1'b1;
        m_valid = 1; m_slot = s; m_lane = lane_now; m_rr = (s + 1) % NS; m_pending = 0;
        if (m_count < 65535) m_count++;
        if (m_count % SPEEDUP == 0 && m_period > P_MIN) begin
          m_period--; m_lvl = 1;
        end
      end else if (due) begin
        m_pending = 1;
      end
    end
  endtask

  function automatic logic [41:0] exp_vec();
    return {m_active, m_valid, 4'(m_slot), m_lane, 8'(m_period), 16'(m_count), m_lvl};
  endfunction

  function automatic logic [41:0] dut_vec();
    return {slot_active, spawn_valid, spawn_slot, spawn_lane, period, spawn_count, level_up};
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input bit rst, input bit en, input bit coll, input logic [NS-1:0] done);
    Reset = rst; enable = en; collision = coll; slot_done = done;
    if (rst) model_reset();
    else model_step(en, coll, done);
    @(posedge Clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(1, 0, 0, '0);
    cycle(1, 0, 0, '0);
    checks++;
    if ({slot_active, spawn_valid, spawn_slot, spawn_lane, level_up} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {slot_active, spawn_valid, spawn_slot, spawn_lane, level_up});
    end
    checks++;
    if (period !== 8'(P_INIT)) begin
      failures++; $display("FAIL reset_period got=%0d exp=%0d", period, P_INIT);
    end
    checks++;
    if (spawn_count !== 16'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", spawn_count);
    end
  endtask

  task automatic test_first_spawn();
    int k;
    cycle(0, 1, 0, '0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL run_entry got=%h exp=%h", dut_vec(), exp_vec());
    end
    for (int n = 0; n < 2; n++) begin
      k = 0;
      do begin
        cycle(0, 1, 0, '0);
        k++;
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; $display("FAIL first_spawn_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
        end
      end while (!spawn_valid && k < 30);
      checks++;
      if (k !== 8) begin
        failures++; $display("FAIL first_spawn_latency n=%0d got=%0d exp=8", n, k);
      end
      checks++;
      if (spawn_slot !== 4'(n) || slot_active !== NS'((1 << (n + 1)) - 1)) begin
        failures++;
        $display("FAIL first_spawn_slot n=%0d got slot=%0d active=%b", n, spawn_slot, slot_active);
      end
    end
    checks++;
    if (spawn_lane !== seed_lane(16)) begin
      failures++; $display("FAIL second_spawn_lane got=%0d exp=%0d", spawn_lane, seed_lane(16));
    end
  endtask

  task automatic test_speedup();
    int n, cyc, last;
    n = 2; cyc = 0; last = 0;
    while (n < 10 && cyc < 200) begin
      cycle(0, 1, 0, '0);
      cyc++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL speedup_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (spawn_valid) begin
        n++;
        if (n == 8) begin
          checks++;
          if (level_up !== 1'b1 || period !== 8'd1) begin
            failures++; $display("FAIL speedup_level got lvl=%0d period=%0d exp lvl=1 period=1", level_up, period);
          end
        end
        if (n >= 9) begin
          checks++;
          if (cyc - last !== 4) begin
            failures++; $display("FAIL speedup_interval n=%0d got=%0d exp=4", n, cyc - last);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (n !== 10) begin
      failures++; $display("FAIL speedup_timeout got spawns=%0d exp=10", n);
    end
  endtask

  task automatic test_pool_full();
    int extra;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, '0);
      if (spawn_valid) extra++;
    end
    checks++;
    if (extra !== 0 || slot_active !== 10'h3FF) begin
      failures++; $display("FAIL pool_full got spawns=%0d active=%h exp 0 / 3ff", extra, slot_active);
    end
    cycle(0, 1, 0, 10'b00_0000_1000);
    checks++;
    if (slot_active !== 10'h3F7 || spawn_valid !== 1'b0) begin
      failures++; $display("FAIL pool_free got active=%h valid=%0d exp 3f7 / 0", slot_active, spawn_valid);
    end
    cycle(0, 1, 0, '0);
    checks++;
    if (spawn_valid !== 1'b1 || spawn_slot !== 4'd3 || slot_active !== 10'h3FF) begin
      failures++;
      $display("FAIL pool_respawn got valid=%0d slot=%0d active=%h exp 1 / 3 / 3ff", spawn_valid, spawn_slot, slot_active);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL pool_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_collision();
    int n, j;
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, '0);
    n = 0; j = 0;
    while (n < 5 && j < 100) begin
      cycle(0, 1, 0, '0);
      j++;
      if (spawn_valid) n++;
    end
    checks++;
    if (slot_active !== 10'h01F || spawn_count !== 16'd5) begin
      failures++; $display("FAIL coll_setup got active=%h count=%0d exp 01f / 5", slot_active, spawn_count);
    end
    cycle(0, 1, 1, '0);
    checks++;
    if (slot_active !== '0 || period !== 8'd2 || spawn_count !== 16'd0) begin
      failures++;
      $display("FAIL coll_flush got active=%h period=%0d count=%0d exp 0 / 2 / 0", slot_active, period, spawn_count);
    end
    j = 0;
    do begin
      cycle(0, 1, 1, '0);
      j++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL coll_model j=%0d got=%h exp=%h", j, dut_vec(), exp_vec());
      end
    end while (!spawn_valid && j < 40);
    checks++;
    if (j !== 21 || spawn_slot !== 4'd5) begin
      failures++; $display("FAIL coll_resume got delay=%0d slot=%0d exp 21 / 5", j, spawn_slot);
    end
  endtask

  task automatic test_enable_drop();
    int j;
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);
    checks++;
    if (slot_active !== '0 || spawn_valid !== 1'b0) begin
      failures++; $display("FAIL idle_clear got active=%h valid=%0d exp 0 / 0", slot_active, spawn_valid);
    end
    cycle(0, 0, 0, 10'h3FF);
    cycle(0, 1, 0, '0);
    j = 0;
    do begin
      cycle(0, 1, 0, '0);
      j++;
    end while (!spawn_valid && j < 30);
    checks++;
    if (j !== 8 || spawn_slot !== 4'd6) begin
      failures++; $display("FAIL reenable got delay=%0d slot=%0d exp 8 / 6", j, spawn_slot);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reenable_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_beats_spawn();
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, '0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, '0);
    cycle(0, 1, 1, '0);
    checks++;
    if (spawn_valid !== 1'b0 || slot_active !== '0 || spawn_count !== 16'd0) begin
      failures++;
      $display("FAIL flush_wins got valid=%0d active=%h count=%0d exp 0 / 0 / 0", spawn_valid, slot_active, spawn_count);
    end
  endtask

  task automatic test_reset_in_cooldown();
    int j;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, '0);
    cycle(1, 1, 0, '0);
    checks++;
    if (dut_vec() !== {10'd0, 1'b0, 4'd0, 2'd0, 8'(P_INIT), 16'd0, 1'b0}) begin
      failures++; $display("FAIL cooldown_reset got=%h", dut_vec());
    end
    cycle(0, 1, 0, '0);
    j = 0;
    do begin
      cycle(0, 1, 0, '0);
      j++;
    end while (!spawn_valid && j < 30);
    checks++;
    if (j !== 8 || spawn_slot !== 4'd0 || spawn_lane !== seed_lane(8)) begin
      failures++;
      $display("FAIL cooldown_reset_spawn got delay=%0d slot=%0d lane=%0d exp 8 / 0 / %0d", j, spawn_slot, spawn_lane, seed_lane(8));
    end
  endtask

  task automatic test_random();
    bit         en, coll, rst;
    logic [NS-1:0] done;
    cycle(1, 0, 0, '0);
    en = 1; coll = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) en = !en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1;
      if ($urandom_range(0, 49) == 0) coll = !coll;
      for (int b = 0; b < NS; b++) done[b] = ($urandom_range(0, 11) == 0);
      cycle(rst, en, coll, done);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; enable = 0; collision = 0; slot_done = '0;
    model_reset();
    test_reset();
    test_first_spawn();
    test_speedup();
    test_pool_full();
    test_collision();
    test_enable_drop();
    test_flush_beats_spawn();
    test_reset_in_cooldown();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
